// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for an RV32I subset core.
// Shares one memory port between fetch and data access and emits one-cycle enable strobes.
module multicycle_sequencer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write_en,
  output logic [2:0]  state,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [7:0] WAIT_LIMIT  = WAIT_MAX[7:0];
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  state_t      r_state;
  logic [6:0]  r_op_q;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_instr_count;
  logic [1:0]  r_fault_code;
  logic        w_wait_expired;

  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: legal = 1'b1;
      default:                                  legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Only meaningful in FETCH (with en) or MEM, where a request is outstanding.
  assign w_wait_expired = (r_wait_cnt == WAIT_LIMIT);

  // State machine, wait counter, retire counter and fault code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_FETCH;
      r_op_q        <= 7'd0;
      r_wait_cnt    <= 8'd0;
      r_instr_count <= 32'd0;
      r_fault_code  <= 2'b00;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!en) begin
            r_wait_cnt <= 8'd0;
          end else if (mem_ready) begin
            r_wait_cnt <= 8'd0;
            r_state    <= S_DECODE;
          end else if (w_wait_expired) begin
            r_fault_code <= CODE_TIMEOUT;
            r_state      <= S_FAULT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DECODE: begin
          r_op_q <= opcode;
          if (is_legal_op(opcode)) begin
            r_state <= S_EXECUTE;
          end else begin
            r_fault_code <= CODE_ILLEGAL;
            r_state      <= S_FAULT;
          end
        end
        S_EXECUTE: begin
          case (r_op_q)
            OP_R, OP_I: r_state <= S_WB;
            OP_LOAD, OP_STORE: begin
              r_wait_cnt <= 8'd0;
              r_state    <= S_MEM;
            end
            OP_BRANCH: begin
              r_instr_count <= r_instr_count + 32'd1;
              r_wait_cnt    <= 8'd0;
              r_state       <= S_FETCH;
            end
            default: begin
              r_fault_code <= CODE_ILLEGAL;
              r_state      <= S_FAULT;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_wait_cnt <= 8'd0;
            if (r_op_q == OP_STORE) begin
              r_instr_count <= r_instr_count + 32'd1;
              r_state       <= S_FETCH;
            end else begin
              r_state <= S_WB;
            end
          end else if (w_wait_expired) begin
            r_fault_code <= CODE_TIMEOUT;
            r_state      <= S_FAULT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          r_instr_count <= r_instr_count + 32'd1;
          r_wait_cnt    <= 8'd0;
          r_state       <= S_FETCH;
        end
        S_FAULT: r_state <= S_FAULT;
        default: begin
          // Unused encodings are treated as corruption of the instruction flow.
          r_fault_code <= CODE_ILLEGAL;
          r_state      <= S_FAULT;
        end
      endcase
    end
  end

  // Memory controls and strobes; Mealy terms use mem_ready, all forced low in reset.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write_en = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = en;
          ir_write = en & mem_ready;
        end
        S_EXECUTE: pc_write = (r_op_q == OP_BRANCH);
        S_MEM: begin
          mem_req      = 1'b1;
          mem_sel_data = 1'b1;
          mem_we       = (r_op_q == OP_STORE);
          pc_write     = (r_op_q == OP_STORE) & mem_ready;
        end
        S_WB: begin
          reg_write_en = 1'b1;
          pc_write     = 1'b1;
        end
        default: mem_req = 1'b0;
      endcase
    end else begin
      mem_req = 1'b0;
    end
  end

  assign state       = r_state;
  assign fault       = (r_state == S_FAULT);
  assign fault_code  = r_fault_code;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus randomized
// instructions checked against a per-instruction cycle/strobe budget model.
module tb_multicycle_sequencer;

  localparam int WMAX = 4;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic        clk, rst_n, en, mem_ready;
  logic [6:0]  opcode;
  logic        mem_req, mem_we, mem_sel_data, ir_write, pc_write, reg_write_en;
  logic [2:0]  state;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] instr_count;

  int          checks, failures;
  logic [31:0] exp_count;

  // Trace of the most recent instruction, one entry per cycle.
  logic [2:0]  tr_state [0:299];
  logic        tr_ir [0:299];
  logic        tr_pc [0:299];
  logic        tr_rw [0:299];
  logic        tr_we [0:299];
  int          n_cyc, n_ir, n_pc, n_rw, n_we, n_req, n_sel;
  logic [2:0]  end_state;

  multicycle_sequencer #(.WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write_en(reg_write_en),
    .state(state), .fault(fault), .fault_code(fault_code), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; mem_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_count = 32'd0;
  endtask

  // Memory answers after fw fetch waits and mw data waits; runs one instruction to FETCH or FAULT.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    int fcnt, mcnt;
    bit done, left;
    fcnt = 0; mcnt = 0; done = 1'b0; left = 1'b0;
    n_cyc = 0; n_ir = 0; n_pc = 0; n_rw = 0; n_we = 0; n_req = 0; n_sel = 0;
    opcode = op; en = 1'b1;
    while (!done && n_cyc < 300) begin
      @(negedge clk);
      if (mem_req && !mem_sel_data) begin mem_ready = (fcnt == fw); fcnt++; end
      else if (mem_req && mem_sel_data) begin mem_ready = (mcnt == mw); mcnt++; end
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      tr_state[n_cyc] = state; tr_ir[n_cyc] = ir_write; tr_pc[n_cyc] = pc_write;
      tr_rw[n_cyc] = reg_write_en; tr_we[n_cyc] = mem_we;
      n_ir += int'(ir_write); n_pc += int'(pc_write); n_rw += int'(reg_write_en);
      n_we += int'(mem_we); n_req += int'(mem_req); n_sel += int'(mem_sel_data);
      n_cyc++;
      @(posedge clk); #1;
      end_state = state;
      if (state != 3'd0) left = 1'b1;
      if (state == 3'd5 || (left && state == 3'd0)) done = 1'b1;
    end
    mem_ready = 1'b0; en = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL run_instr_bound op=%b never completed after %0d cycles", op, n_cyc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; mem_ready = 1'b1; opcode = OP_R;
    #1;
    checks++; if (mem_req !== 1'b0 || ir_write !== 1'b0) begin failures++; $display("FAIL reset_outputs mem_req=%b ir_write=%b exp 0", mem_req, ir_write); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (instr_count !== 32'd0 || fault !== 1'b0 || fault_code !== 2'b00) begin failures++; $display("FAIL reset_regs count=%0d fault=%b code=%b exp 0/0/00", instr_count, fault, fault_code); end
    do_reset();
  endtask

  task automatic test_add();
    do_reset();
    run_instr(OP_R, 0, 0); exp_count++;
    checks++; if (n_cyc !== 4) begin failures++; $display("FAIL add_cycles got=%0d exp=4", n_cyc); end
    checks++; if ({tr_state[0], tr_state[1], tr_state[2], tr_state[3]} !== {3'd0, 3'd1, 3'd2, 3'd4}) begin failures++; $display("FAIL add_states got=%0d,%0d,%0d,%0d exp=0,1,2,4", tr_state[0], tr_state[1], tr_state[2], tr_state[3]); end
    checks++; if (tr_ir[0] !== 1'b1 || n_ir !== 1) begin failures++; $display("FAIL add_ir_write cyc0=%b total=%0d exp 1/1", tr_ir[0], n_ir); end
    checks++; if (tr_rw[3] !== 1'b1 || tr_pc[3] !== 1'b1 || n_pc !== 1 || n_rw !== 1) begin failures++; $display("FAIL add_wb_strobes rw=%b pc=%b npc=%0d nrw=%0d exp 1/1/1/1", tr_rw[3], tr_pc[3], n_pc, n_rw); end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL add_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LOAD, 0, 3); exp_count++;
    checks++; if (n_cyc !== 8) begin failures++; $display("FAIL lw_cycles got=%0d exp=8", n_cyc); end
    checks++; if (n_sel !== 4 || n_we !== 0) begin failures++; $display("FAIL lw_mem sel_cycles=%0d we_cycles=%0d exp 4/0", n_sel, n_we); end
    checks++; if (tr_state[7] !== 3'd4 || tr_rw[7] !== 1'b1 || n_pc !== 1) begin failures++; $display("FAIL lw_wb state=%0d rw=%b npc=%0d exp 4/1/1", tr_state[7], tr_rw[7], n_pc); end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL lw_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  task automatic test_sw_beq();
    run_instr(OP_STORE, 0, 0); exp_count++;
    checks++; if (n_cyc !== 4 || n_we !== 1 || tr_we[3] !== 1'b1) begin failures++; $display("FAIL sw_timing cycles=%0d we_cycles=%0d we3=%b exp 4/1/1", n_cyc, n_we, tr_we[3]); end
    checks++; if (tr_pc[3] !== 1'b1 || n_pc !== 1 || n_rw !== 0) begin failures++; $display("FAIL sw_strobes pc3=%b npc=%0d nrw=%0d exp 1/1/0", tr_pc[3], n_pc, n_rw); end
    run_instr(OP_BRANCH, 0, 0); exp_count++;
    checks++; if (n_cyc !== 3 || tr_pc[2] !== 1'b1 || n_pc !== 1) begin failures++; $display("FAIL beq_timing cycles=%0d pc2=%b npc=%0d exp 3/1/1", n_cyc, tr_pc[2], n_pc); end
    checks++; if (n_req !== 1 || n_rw !== 0) begin failures++; $display("FAIL beq_mem req_cycles=%0d nrw=%0d exp 1/0", n_req, n_rw); end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL sw_beq_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 0, 0);
    checks++; if (n_cyc !== 2 || end_state !== 3'd5) begin failures++; $display("FAIL illegal_entry cycles=%0d state=%0d exp 2/5", n_cyc, end_state); end
    checks++; if (fault !== 1'b1 || fault_code !== 2'b01) begin failures++; $display("FAIL illegal_code fault=%b code=%b exp 1/01", fault, fault_code); end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      checks++; if (mem_req !== 1'b0 || state !== 3'd5 || ir_write !== 1'b0) begin failures++; $display("FAIL illegal_absorb req=%b state=%0d ir=%b exp 0/5/0", mem_req, state, ir_write); end
    end
    checks++; if (instr_count !== exp_count) begin failures++; $display("FAIL illegal_count got=%0d exp=%0d", instr_count, exp_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    run_instr(OP_R, 255, 0);
    checks++; if (n_cyc !== WMAX + 1 || end_state !== 3'd5) begin failures++; $display("FAIL timeout_entry cycles=%0d state=%0d exp %0d/5", n_cyc, end_state, WMAX + 1); end
    checks++; if (fault_code !== 2'b10 || n_ir !== 0) begin failures++; $display("FAIL timeout_code code=%b nir=%0d exp 10/0", fault_code, n_ir); end
    do_reset();
    run_instr(OP_R, WMAX, 0); exp_count++;
    checks++; if (n_cyc !== 4 + WMAX || end_state !== 3'd0 || fault !== 1'b0) begin failures++; $display("FAIL timeout_edge cycles=%0d state=%0d fault=%b exp %0d/0/0", n_cyc, end_state, fault, 4 + WMAX); end
    checks++; if (tr_state[WMAX + 1] !== 3'd1) begin failures++; $display("FAIL timeout_edge_decode got=%0d exp=1", tr_state[WMAX + 1]); end
  endtask

  task automatic test_reset_mid_mem();
    int mcyc;
    do_reset();
    run_instr(OP_R, 0, 0);
    opcode = OP_LOAD; en = 1'b1; mcyc = 0;
    for (int k = 0; k < 20 && mcyc < 2; k++) begin
      @(negedge clk); mem_ready = (state == 3'd0); #1;
      if (state == 3'd3) mcyc++;
      if (mcyc < 2) begin @(posedge clk); #1; end
    end
    checks++; if (state !== 3'd3 || mem_req !== 1'b1 || instr_count !== 32'd1) begin failures++; $display("FAIL midmem_setup state=%0d req=%b count=%0d exp 3/1/1", state, mem_req, instr_count); end
    rst_n = 1'b0; #1;
    checks++; if ({mem_req, mem_we, mem_sel_data, ir_write, pc_write, reg_write_en} !== 6'd0) begin failures++; $display("FAIL midmem_outputs got=%b exp=000000", {mem_req, mem_we, mem_sel_data, ir_write, pc_write, reg_write_en}); end
    checks++; if (state !== 3'd0 || instr_count !== 32'd0 || fault !== 1'b0) begin failures++; $display("FAIL midmem_regs state=%0d count=%0d fault=%b exp 0/0/0", state, instr_count, fault); end
    do_reset();
  endtask

  task automatic test_en_low();
    do_reset();
    opcode = OP_R; en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); mem_ready = (i == 2); #1;
      checks++; if (mem_req !== 1'b0 || ir_write !== 1'b0 || state !== 3'd0 || fault !== 1'b0) begin failures++; $display("FAIL en_low_hold req=%b ir=%b state=%0d fault=%b exp 0/0/0/0", mem_req, ir_write, state, fault); end
    end
    @(posedge clk); #1;
    run_instr(OP_I, 1, 0); exp_count++;
    checks++; if (n_cyc !== 5 || end_state !== 3'd0 || instr_count !== exp_count) begin failures++; $display("FAIL en_low_resume cycles=%0d state=%0d count=%0d exp 5/0/%0d", n_cyc, end_state, instr_count, exp_count); end
  endtask

  task automatic test_random();
    logic [6:0] ops [0:4];
    logic [6:0] op;
    int fw, mw, ecyc, ereq;
    bit is_mem, efault;
    logic [1:0] ecode;
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LOAD; ops[3] = OP_STORE; ops[4] = OP_BRANCH;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        op = 7'($urandom);
        if (is_legal(op)) op = 7'b1111111;
      end else begin
        op = ops[$urandom_range(0, 4)];
      end
      fw = int'($urandom_range(0, 5));
      mw = int'($urandom_range(0, 5));
      is_mem = (op == OP_LOAD) || (op == OP_STORE);
      efault = 1'b1; ecode = 2'b10; ereq = 0;
      if (fw > WMAX) ecyc = WMAX + 1;
      else if (!is_legal(op)) begin ecyc = fw + 2; ecode = 2'b01; end
      else if (is_mem && mw > WMAX) ecyc = fw + 3 + WMAX + 1;
      else begin
        efault = 1'b0; ecode = 2'b00;
        ecyc = (op == OP_LOAD) ? 5 : (op == OP_BRANCH) ? 3 : 4;
        ecyc += fw + (is_mem ? mw : 0);
        ereq = fw + 1 + (is_mem ? mw + 1 : 0);
      end
      run_instr(op, fw, mw);
      if (!efault) exp_count++;
      checks++; if (n_cyc !== ecyc || end_state !== (efault ? 3'd5 : 3'd0)) begin failures++; $display("FAIL rand_cycles it=%0d op=%b fw=%0d mw=%0d cycles=%0d state=%0d exp %0d/%0d", it, op, fw, mw, n_cyc, end_state, ecyc, efault ? 5 : 0); end
      checks++; if (fault !== efault || fault_code !== ecode || instr_count !== exp_count) begin failures++; $display("FAIL rand_status it=%0d fault=%b code=%b count=%0d exp %b/%b/%0d", it, fault, fault_code, instr_count, efault, ecode, exp_count); end
      if (!efault) begin
        checks++;
        if (n_ir !== 1 || n_pc !== 1 || n_rw !== ((op == OP_STORE || op == OP_BRANCH) ? 0 : 1) ||
            n_we !== ((op == OP_STORE) ? mw + 1 : 0) || n_req !== ereq) begin
          failures++;
          $display("FAIL rand_strobes it=%0d op=%b ir=%0d pc=%0d rw=%0d we=%0d req=%0d exp_req=%0d", it, op, n_ir, n_pc, n_rw, n_we, n_req, ereq);
        end
      end else begin
        do_reset();
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; exp_count = 32'd0;
    rst_n = 1'b0; en = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_beq();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_en_low();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
